// File: rtl/simd_lane_shifter_pipe_if.sv
// Handshake and data bundle for simd_lane_shifter_pipe.
// master: the side that issues operands and consumes results.
// slave : the shifter pipeline itself.
interface simd_lane_shifter_pipe_if #(
    parameter int DATA_W = 512,
    parameter int LANE_W = 8
);
    localparam int LANES = DATA_W / LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] dd;
    logic [DATA_W-1:0] aa;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] shift;
    logic [LANES-1:0]  out_ovf;

    modport master (
        output in_valid, in_mode, dd, aa, out_ready,
        input  in_ready, out_valid, shift, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, dd, aa, out_ready,
        output in_ready, out_valid, shift, out_ovf
    );
endinterface

// File: rtl/simd_lane_shifter_pipe.sv
// Pipelined per-lane SIMD shifter: SLL / SRL / SRA and optional rotate-left.
// One pipeline stage per shift-amount bit (stage k shifts by 2^k).
// Over-range amounts (any bit at or above SAW set) are flagged per lane and
// resolved by a combinational fixup on the last stage register.
// Optional feature macro: SIMD_SHIFT_ROTATE_EN -- when defined, mode 2'b11 is a
// per-lane rotate-left (amount mod LANE_W, never flagged); when undefined,
// mode 2'b11 behaves exactly like SLL.
module simd_lane_shifter_pipe #(
    parameter int DATA_W = 512,
    parameter int LANE_W = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    simd_lane_shifter_pipe_if.slave bus
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int SAW   = $clog2(LANE_W);
    localparam int AMW   = LANES * SAW;

    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    // One shift step of a single lane by a constant power of two.
    // SRA fills from the lane's original sign, not from the current MSB,
    // so later stages stay correct even after earlier ones moved bits.
    function automatic logic [LANE_W-1:0] f_step(
        input logic [LANE_W-1:0] v,
        input logic [1:0]        mode,
        input logic              sgn,
        input int                sh
    );
        logic [LANE_W-1:0] r;
        logic [LANE_W-1:0] fill;
        fill = sgn ? ~({LANE_W{1'b1}} >> sh) : '0;
        case (mode)
            MODE_SRL: r = v >> sh;
            MODE_SRA: r = (v >> sh) | fill;
`ifdef SIMD_SHIFT_ROTATE_EN
            2'b11:    r = (v << sh) | (v >> (LANE_W - sh));
`endif
            default:  r = v << sh;
        endcase
        return r;
    endfunction

    logic              w_en;
    logic              w_rot;
    logic [SAW-1:0]    r_vld;

    // Stage inputs (index k feeds stage k) and stage results
    logic [DATA_W-1:0] w_data_in  [SAW];
    logic [AMW-1:0]    w_amt_in   [SAW];
    logic [LANES-1:0]  w_ovf_in   [SAW];
    logic [LANES-1:0]  w_sign_in  [SAW];
    logic [1:0]        w_mode_in  [SAW];
    logic [DATA_W-1:0] w_data_nxt [SAW];

    // Intermediate stage registers (stages 0..SAW-2), not reset
    logic [DATA_W-1:0] r_data_p [SAW-1];
    logic [AMW-1:0]    r_amt_p  [SAW-1];
    logic [LANES-1:0]  r_ovf_p  [SAW-1];
    logic [LANES-1:0]  r_sign_p [SAW-1];
    logic [1:0]        r_mode_p [SAW-1];

    // Final stage registers, reset so the output reads zero out of reset
    logic [DATA_W-1:0] r_fin_data;
    logic [LANES-1:0]  r_fin_ovf;
    logic [LANES-1:0]  r_fin_sign;
    logic [1:0]        r_fin_mode;

    // Single global advance: the whole pipe moves or the whole pipe holds
    assign w_en          = !r_vld[SAW-1] || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_vld[SAW-1];

`ifdef SIMD_SHIFT_ROTATE_EN
    assign w_rot = (r_fin_mode == 2'b11);
`else
    assign w_rot = 1'b0;
`endif

    // Decode the incoming vector and route each later stage from its predecessor
    always_comb begin
        w_data_in[0] = bus.dd;
        w_mode_in[0] = bus.in_mode;
        w_amt_in[0]  = '0;
        w_ovf_in[0]  = '0;
        w_sign_in[0] = '0;
        for (int l = 0; l < LANES; l++) begin
            w_amt_in[0][l*SAW +: SAW] = bus.aa[l*LANE_W +: SAW];
            w_ovf_in[0][l]            = |bus.aa[l*LANE_W+SAW +: LANE_W-SAW];
            w_sign_in[0][l]           = bus.dd[l*LANE_W + LANE_W-1];
        end
        for (int k = 1; k < SAW; k++) begin
            w_data_in[k] = r_data_p[k-1];
            w_amt_in[k]  = r_amt_p[k-1];
            w_ovf_in[k]  = r_ovf_p[k-1];
            w_sign_in[k] = r_sign_p[k-1];
            w_mode_in[k] = r_mode_p[k-1];
        end
    end

    // Stage k shifts every lane whose amount bit k is set by 2^k
    always_comb begin
        for (int k = 0; k < SAW; k++) begin
            w_data_nxt[k] = w_data_in[k];
            for (int l = 0; l < LANES; l++) begin
                if (w_amt_in[k][l*SAW + k]) begin
                    w_data_nxt[k][l*LANE_W +: LANE_W] =
                        f_step(w_data_in[k][l*LANE_W +: LANE_W], w_mode_in[k],
                               w_sign_in[k][l], 1 << k);
                end
            end
        end
    end

    // Valid bits travel with the data; bubbles are kept, never collapsed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[SAW-2:0], bus.in_valid};
        end
    end

    // Intermediate payload registers; validity is carried by r_vld only
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int k = 0; k < SAW-1; k++) begin
                r_data_p[k] <= w_data_nxt[k];
                r_amt_p[k]  <= w_amt_in[k];
                r_ovf_p[k]  <= w_ovf_in[k];
                r_sign_p[k] <= w_sign_in[k];
                r_mode_p[k] <= w_mode_in[k];
            end
        end
    end

    // Last stage register, which is also the held output while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_data <= '0;
            r_fin_ovf  <= '0;
            r_fin_sign <= '0;
            r_fin_mode <= '0;
        end else if (w_en) begin
            r_fin_data <= w_data_nxt[SAW-1];
            r_fin_ovf  <= w_ovf_in[SAW-1];
            r_fin_sign <= w_sign_in[SAW-1];
            r_fin_mode <= w_mode_in[SAW-1];
        end
    end

    // Over-range fixup: zero for logical shifts, sign fill for SRA, none for rotate
    always_comb begin
        bus.shift   = r_fin_data;
        bus.out_ovf = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_fin_ovf[l] && !w_rot) begin
                bus.out_ovf[l] = 1'b1;
                bus.shift[l*LANE_W +: LANE_W] =
                    (r_fin_mode == MODE_SRA) ? {LANE_W{r_fin_sign[l]}} : '0;
            end
        end
    end

endmodule

// File: tb/tb_simd_lane_shifter_pipe.sv
// Scoreboard bench for simd_lane_shifter_pipe (DATA_W=512, LANE_W=8).
// Expected results for mode 2'b11 follow SIMD_SHIFT_ROTATE_EN.
module tb_simd_lane_shifter_pipe;
    localparam int DATA_W = 512;
    localparam int LANE_W = 8;
    localparam int LANES  = 64;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [1:0]        mode;
        logic [DATA_W-1:0] dd;
        logic [DATA_W-1:0] aa;
        logic [DATA_W-1:0] es;
        logic [LANES-1:0]  eo;
    } txn_t;

    typedef struct packed {
        logic [DATA_W-1:0] s;
        logic [LANES-1:0]  o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simd_lane_shifter_pipe_if #(.DATA_W(DATA_W), .LANE_W(LANE_W)) bus();

    simd_lane_shifter_pipe #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    txn_t tv[10];
    txn_t t_idle;

    task automatic chk(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic txn_t new_txn(input logic [1:0] mode);
        txn_t t;
        t      = '0;
        t.mode = mode;
        return t;
    endfunction

    function automatic txn_t add_lane(input txn_t t, input int lane, input logic [7:0] d,
                                      input logic [7:0] a, input logic [7:0] e, input logic o);
        txn_t r;
        r                   = t;
        r.dd[lane*8 +: 8]   = d;
        r.aa[lane*8 +: 8]   = a;
        r.es[lane*8 +: 8]   = e;
        r.eo[lane]          = o;
        return r;
    endfunction

    // One cycle: drive after the rising edge, sample handshake at the falling edge
    task automatic drive_cycle(input logic v, input txn_t t, input logic ordy,
                               output logic acc, output logic rdy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_mode   = t.mode;
        bus.dd        = t.dd;
        bus.aa        = t.aa;
        bus.out_ready = ordy;
        @(negedge clk);
        rdy = bus.in_ready;
        acc = v && rdy;
        if (acc) sb.push_back({t.es, t.eo});
    endtask

    task automatic send(input txn_t t);
        logic acc, rdy;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive_cycle(1'b1, t, 1'b1, acc, rdy);
            tries++;
        end
        chk("send accepted", acc, 1);
    endtask

    task automatic drain();
        logic acc, rdy;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            drive_cycle(1'b0, t_idle, 1'b1, acc, rdy);
            n++;
        end
        chk("scoreboard drained", sb.size(), 0);
    endtask

    // Monitor: compare every consumed result and check stability under stall
    logic              stalled = 1'b0;
    logic [DATA_W-1:0] h_s;
    logic [LANES-1:0]  h_o;
    exp_t              e_cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold out_valid", bus.out_valid, 1);
                chk("hold shift", bus.shift, h_s);
                chk("hold out_ovf", bus.out_ovf, h_o);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected output: got shift %0h, no result was expected", bus.shift);
                end else begin
                    e_cur = sb.pop_front();
                    chk("shift", bus.shift, e_cur.s);
                    chk("out_ovf", bus.out_ovf, e_cur.o);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_s     = bus.shift;
            h_o     = bus.out_ovf;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, rdy;
        int   lat, idx;
        logic [7:0] a8, e8;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.dd        = '0;
        bus.aa        = '0;
        bus.out_ready = 1'b1;
        t_idle        = '0;

        tv[0] = add_lane(new_txn(2'b00), 0, 8'h43, 8'h01, 8'h86, 1'b0);
        tv[1] = add_lane(add_lane(new_txn(2'b00), 38, 8'h19, 8'h04, 8'h90, 1'b0),
                         63, 8'h01, 8'h09, 8'h00, 1'b1);
        tv[2] = add_lane(new_txn(2'b10), 5, 8'h90, 8'h03, 8'hF2, 1'b0);
        tv[3] = add_lane(new_txn(2'b10), 5, 8'h90, 8'h0A, 8'hFF, 1'b1);
        tv[4] = add_lane(new_txn(2'b01), 5, 8'h90, 8'h03, 8'h12, 1'b0);
        tv[5] = new_txn(2'b00);
        tv[5] = add_lane(tv[5], 1, 8'h01, 8'h07, 8'h80, 1'b0);
        tv[5] = add_lane(tv[5], 2, 8'hFF, 8'h08, 8'h00, 1'b1);
        tv[5] = add_lane(tv[5], 3, 8'hA5, 8'h00, 8'hA5, 1'b0);
        tv[5] = add_lane(tv[5], 4, 8'h5A, 8'hFF, 8'h00, 1'b1);
        tv[6] = new_txn(2'b10);
        tv[6] = add_lane(tv[6], 7, 8'h80, 8'h07, 8'hFF, 1'b0);
        tv[6] = add_lane(tv[6], 8, 8'h7F, 8'h07, 8'h00, 1'b0);
        tv[6] = add_lane(tv[6], 9, 8'h7F, 8'h10, 8'h00, 1'b1);
        tv[6] = add_lane(tv[6], 10, 8'h85, 8'h00, 8'h85, 1'b0);
        tv[7] = new_txn(2'b01);
        tv[7] = add_lane(tv[7], 10, 8'h80, 8'h07, 8'h01, 1'b0);
        tv[7] = add_lane(tv[7], 11, 8'hFF, 8'h08, 8'h00, 1'b1);
        tv[7] = add_lane(tv[7], 12, 8'hA5, 8'h00, 8'hA5, 1'b0);
        tv[8] = new_txn(2'b11);
`ifdef SIMD_SHIFT_ROTATE_EN
        tv[8] = add_lane(tv[8], 0, 8'h81, 8'h01, 8'h03, 1'b0);
        tv[8] = add_lane(tv[8], 1, 8'h81, 8'h09, 8'h03, 1'b0);
        tv[8] = add_lane(tv[8], 3, 8'h81, 8'h08, 8'h81, 1'b0);
`else
        tv[8] = add_lane(tv[8], 0, 8'h81, 8'h01, 8'h02, 1'b0);
        tv[8] = add_lane(tv[8], 1, 8'h81, 8'h09, 8'h00, 1'b1);
        tv[8] = add_lane(tv[8], 3, 8'h81, 8'h08, 8'h00, 1'b1);
`endif
        tv[8] = add_lane(tv[8], 2, 8'hC3, 8'h00, 8'hC3, 1'b0);
        tv[9] = new_txn(2'b00);
        for (int l = 0; l < LANES; l++) begin
            a8 = 8'(l % 12);
            e8 = (a8 >= 8) ? 8'h00 : (8'hFF << a8);
            tv[9] = add_lane(tv[9], l, 8'hFF, a8, e8, a8 >= 8);
        end

        // Reset values
        #12;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset shift", bus.shift, 0);
        chk("reset out_ovf", bus.out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b0, t_idle, 1'b1, acc, rdy);
        chk("in_ready after reset", rdy, 1);

        // Latency of a single isolated transaction
        drive_cycle(1'b1, tv[0], 1'b1, acc, rdy);
        chk("first accept", acc, 1);
        lat = 0;
        do begin
            drive_cycle(1'b0, t_idle, 1'b1, acc, rdy);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk("latency", lat, LAT);
        drain();

        // Full-rate stream of the directed vectors
        for (int i = 1; i < 10; i++) send(tv[i]);
        drain();

        // Back-to-back with downstream stall in cycles 4..6
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            drive_cycle(1'b1, tv[idx], !(c >= 4 && c <= 6), acc, rdy);
            if (c >= 4 && c <= 6) chk("in_ready while stalled", rdy, 0);
            if (acc) idx++;
        end
        chk("stall stream accepted count", idx, 8);
        drain();

        // Reset with two transactions in flight, one stalled at the output
        drive_cycle(1'b1, tv[2], 1'b0, acc, rdy);
        drive_cycle(1'b1, tv[3], 1'b0, acc, rdy);
        drive_cycle(1'b0, t_idle, 1'b0, acc, rdy);
        drive_cycle(1'b0, t_idle, 1'b0, acc, rdy);
        chk("out_valid before mid reset", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", bus.out_valid, 0);
        chk("mid reset shift", bus.shift, 0);
        chk("mid reset out_ovf", bus.out_ovf, 0);
        sb.delete();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, t_idle, 1'b1, acc, rdy);
            chk("no stale output after reset", bus.out_valid, 0);
        end
        send(tv[8]);
        send(tv[9]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
